// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide on magnitudes.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             dbz
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           op_q, op_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 dbz_q, dbz_d;

   logic                 is_signed;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_rem, div_diff;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     div_sel, fix_word;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0]   a_ext, b_ext, fast_prod;
`endif

   // acc_q holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide.
   always_comb begin
      is_signed = ~op[0];
      a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
      b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

      div_rem   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_rem - {1'b0, opnd_q};
      if (!div_diff[WIDTH])
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         div_next = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

      prod_fix  = neg_q ? -acc_q : acc_q;
      div_sel   = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
      if (op_q[2])
         fix_word = neg_q ? -div_sel : div_sel;
      else
         fix_word = op_q[1] ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];

`ifdef MULDIV_FAST_MUL_EN
      a_ext     = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
      b_ext     = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
      fast_prod = a_ext * b_ext;
`endif
   end

   // Next-state logic; flush overrides everything, including a same-cycle start.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      result_d = result_q;
      dbz_d    = dbz_q;

      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            CALC: begin
               cnt_d = cnt_q + 1'b1;
               acc_d = op_q[2] ? div_next : mul_next;
               if (cnt_q == CW'(WIDTH - 1))
                  state_d = FIX;
            end
            FIX: begin
               result_d = fix_word;
               dbz_d    = op_q[2] && (opnd_q == '0);
               state_d  = DONE;
            end
            default: begin
               state_d = IDLE;
               if (start) begin
                  op_d  = op;
                  cnt_d = '0;
                  dbz_d = 1'b0;
                  if (op[2]) begin
                     opnd_d = b_mag;
                     neg_d  = op[1] ? (is_signed & a[WIDTH-1])
                                    : (is_signed & (a[WIDTH-1] ^ b[WIDTH-1]));
                     if (b == '0) begin
                        // Preload so FIX yields all-ones quotient and raw dividend remainder.
                        acc_d   = {a, {WIDTH{1'b1}}};
                        neg_d   = 1'b0;
                        state_d = FIX;
                     end else begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        state_d = CALC;
                     end
                  end else begin
`ifdef MULDIV_FAST_MUL_EN
                     result_d = op[1] ? fast_prod[2*WIDTH-1:WIDTH] : fast_prod[WIDTH-1:0];
                     state_d  = DONE;
`else
                     opnd_d  = a_mag;
                     acc_d   = {{WIDTH{1'b0}}, b_mag};
                     neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                     state_d = CALC;
`endif
                  end
               end
            end
         endcase
      end

      busy_d = (state_d == CALC) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign dbz    = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_seq;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam logic MUL_BUSY = (MUL_LAT != 1);

   logic          clk = 1'b0;
   logic          rst, start, flush;
   logic [2:0]    op;
   logic [W-1:0]  a, b;
   logic          busy, done, dbz;
   logic [W-1:0]  result;

   int            checks = 0;
   int            errors = 0;

   int            lat;
   logic [W-1:0]  res, res_next, inj_res;
   logic          dz, busy1, done_next, inj_busy, inj_done, inj_dbz;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
      .busy(busy), .done(done), .result(result), .dbz(dbz)
   );

   // Free-running clock; outputs are sampled on the falling edge.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Issue one op, then watch up to 60 cycles; inj_kind 1=start, 2=flush, 3=rst at inj_cyc.
   task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                input int inj_cyc, input int inj_kind);
      int cyc;
      @(negedge clk);
      start = 1'b1; op = o; a = aa; b = bb;
      @(posedge clk);
      lat = 0; cyc = 0; done_next = 1'b0; res_next = '0;
      while (cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) busy1 = busy;
         if (inj_kind != 0 && cyc == inj_cyc + 1) begin
            inj_busy = busy; inj_done = done; inj_res = result; inj_dbz = dbz;
         end
         start = 1'b0; flush = 1'b0; rst = 1'b0;
         if (cyc == 1) begin a = ~aa; b = ~bb; op = ~o; end
         if (cyc == inj_cyc) begin
            case (inj_kind)
               1: begin start = 1'b1; op = 3'b001; end
               2: flush = 1'b1;
               3: rst = 1'b1;
               default: ;
            endcase
         end
         if (done) begin
            lat = cyc; res = result; dz = dbz;
            break;
         end
         if (inj_kind >= 2 && cyc == inj_cyc + 1) break;
      end
      start = 1'b0; flush = 1'b0; rst = 1'b0;
      if (lat != 0) begin
         @(negedge clk);
         done_next = done; res_next = result;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_result", 64'(result), 64'd0);
      checkOutput("reset_dbz", 64'(dbz), 64'd0);
      rst = 1'b0;

      applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 0, 0);
      checkOutput("mul_lat", 64'(lat), 64'(MUL_LAT));
      checkOutput("mul_busy1", 64'(busy1), 64'(MUL_BUSY));
      checkOutput("mul_res", 64'(res), 64'hFFFF_FFEB);
      checkOutput("mul_dbz", 64'(dz), 64'd0);
      checkOutput("mul_done_pulse", 64'(done_next), 64'd0);
      checkOutput("mul_res_hold", 64'(res_next), 64'hFFFF_FFEB);

      applyStimulus(3'b010, 32'd7, 32'hFFFF_FFFD, 0, 0);
      checkOutput("muh_lat", 64'(lat), 64'(MUL_LAT));
      checkOutput("muh_res", 64'(res), 64'hFFFF_FFFF);

      applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      checkOutput("muhu_res", 64'(res), 64'hFFFF_FFFE);

      applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      checkOutput("mulu_res", 64'(res), 64'h0000_0001);

      applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 0, 0);
      checkOutput("div_lat", 64'(lat), 64'd34);
      checkOutput("div_busy1", 64'(busy1), 64'd1);
      checkOutput("div_res", 64'(res), 64'hFFFF_FFFD);
      checkOutput("div_dbz", 64'(dz), 64'd0);

      applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 0, 0);
      checkOutput("mod_res", 64'(res), 64'hFFFF_FFFF);

      applyStimulus(3'b101, 32'd100, 32'd0, 0, 0);
      checkOutput("divu0_lat", 64'(lat), 64'd2);
      checkOutput("divu0_res", 64'(res), 64'hFFFF_FFFF);
      checkOutput("divu0_dbz", 64'(dz), 64'd1);
      checkOutput("divu0_done_pulse", 64'(done_next), 64'd0);

      applyStimulus(3'b111, 32'd100, 32'd0, 0, 0);
      checkOutput("modu0_lat", 64'(lat), 64'd2);
      checkOutput("modu0_res", 64'(res), 64'd100);
      checkOutput("modu0_dbz", 64'(dz), 64'd1);

      applyStimulus(3'b101, 32'd1000, 32'd7, 15, 2);
      checkOutput("flush_busy", 64'(inj_busy), 64'd0);
      checkOutput("flush_done", 64'(inj_done), 64'd0);
      checkOutput("flush_res", 64'(inj_res), 64'd100);

      applyStimulus(3'b101, 32'd1000, 32'd7, 0, 0);
      checkOutput("divu_lat", 64'(lat), 64'd34);
      checkOutput("divu_res", 64'(res), 64'd142);
      checkOutput("divu_dbz", 64'(dz), 64'd0);

      applyStimulus(3'b111, 32'd1000, 32'd7, 0, 0);
      checkOutput("modu_res", 64'(res), 64'd6);

      applyStimulus(3'b001, 32'd3, 32'd5, 5, 3);
      checkOutput("rst_busy", 64'(inj_busy), 64'd0);
      checkOutput("rst_done", 64'(inj_done), 64'd0);
      checkOutput("rst_result", 64'(inj_res), 64'd0);
      checkOutput("rst_dbz", 64'(inj_dbz), 64'd0);

      applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1);
      checkOutput("ovf_div_lat", 64'(lat), 64'd34);
      checkOutput("ovf_div_res", 64'(res), 64'h8000_0000);
      checkOutput("ovf_div_dbz", 64'(dz), 64'd0);

      applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      checkOutput("ovf_mod_lat", 64'(lat), 64'd34);
      checkOutput("ovf_mod_res", 64'(res), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
